// File: rtl/div_ratio_sched_if.sv
// div_ratio_sched_if
//   Request/status bundle between a ratio requester and div_ratio_sched.
//   Handshake: the requester holds req_valid/req_n/req_frac. The scheduler
//   raises req_ready only while idle. A request is taken on the rising edge
//   where req_valid && req_ready are both high.
//
//   req_valid  requester -> scheduler  a new divide ratio is offered
//   req_n      requester -> scheduler  integer divide ratio, 1..7
//   req_frac   requester -> scheduler  fractional part in eighths (dither build)
//   req_ready  scheduler -> requester  request accepted this cycle
//   n_out      scheduler -> requester  ratio applied to the divider N input
//   wrap       scheduler -> requester  last cycle of each divider period
//   busy       scheduler -> requester  ratio change in progress
//   settled    scheduler -> requester  ratio stable for SETTLE_LEN cycles
//   err        scheduler -> requester  pulse: req_n==0 request rejected
interface div_ratio_sched_if;
   logic       req_valid;
   logic [2:0] req_n;
   logic [2:0] req_frac;
   logic       req_ready;
   logic [2:0] n_out;
   logic       wrap;
   logic       busy;
   logic       settled;
   logic       err;

   modport master (
      output req_valid, req_n, req_frac,
      input  req_ready, n_out, wrap, busy, settled, err
   );

   modport slave (
      input  req_valid, req_n, req_frac,
      output req_ready, n_out, wrap, busy, settled, err
   );
endinterface

// File: rtl/div_ratio_sched.sv
// div_ratio_sched
//   Schedules divide-ratio changes for an integer clock divider so that N only
//   changes on a period boundary, then holds off new requests for SETTLE_LEN
//   cycles while the downstream clock settles. A 4-bit phase counter mirrors
//   the divider to know where the period boundary is.
//
//   Optional feature: define DIV_DITHER_EN to add fractional-N dithering
//   (3-bit accumulator of req_frac, +1 on the period after each carry).
//
// Parameters
//   SETTLE_LEN  cycles spent settling after a ratio change (1..15)
//   RESET_N     divide ratio driven on n_out after reset
// Ports
//   CLK_out     clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         request/status bundle (slave side)
//   state_dbg   current FSM state (0 IDLE, 1 WAIT_WRAP, 2 SETTLE)
module div_ratio_sched #(
   parameter int unsigned SETTLE_LEN = 8,
   parameter logic [2:0]  RESET_N    = 3'd1
) (
   input  logic             CLK_out,
   input  logic             rst_n,
   div_ratio_sched_if.slave bus,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_WRAP = 2'd1,
      SETTLE    = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_LEN - 1);

   state_t     state_q, state_d;
   logic [3:0] phase_q;
   logic [2:0] n_q;
   logic [2:0] pend_n_q;
   logic [3:0] settle_cnt_q;
   logic       busy_q;
   logic       settled_q;
   logic       err_q;

   logic       wrap;
   logic       ready;
   logic       zero_req;
   logic       same_req;
   logic       start;
   logic       apply;
   logic       settle_done;

   // Last cycle of the current divider period.
   assign wrap = (phase_q == ({1'b0, n_q} - 4'd1));

`ifdef DIV_DITHER_EN
   logic [2:0] base_q;
   logic [2:0] frac_q;
   logic [2:0] pend_frac_q;
   logic [2:0] acc_q;
   logic [3:0] dsum;
   logic [2:0] n_up;

   assign dsum = {1'b0, acc_q} + {1'b0, frac_q};
   assign n_up = (base_q == 3'd7) ? 3'd7 : base_q + 3'd1;
   // A repeat request matches only if both integer and fractional parts match.
   assign same_req = (bus.req_n == base_q) && (bus.req_frac == frac_q);
`else
   logic frac_unused;
   assign frac_unused = ^bus.req_frac;
   assign same_req = (bus.req_n == n_q);
`endif

   // FSM state register
   always_ff @(posedge CLK_out or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and decoded strobes
   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      zero_req    = 1'b0;
      start       = 1'b0;
      apply       = 1'b0;
      settle_done = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) begin
               if (bus.req_n == 3'd0) begin
                  zero_req = 1'b1;
               end else if (!same_req) begin
                  start   = 1'b1;
                  state_d = WAIT_WRAP;
               end
            end
         end
         WAIT_WRAP: begin
            // Only switch on the period boundary so no period is truncated.
            if (wrap) begin
               apply   = 1'b1;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_done = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge CLK_out or negedge rst_n) begin
      if (!rst_n) begin
         n_q          <= RESET_N;
         phase_q      <= 4'd0;
         pend_n_q     <= 3'd0;
         settle_cnt_q <= 4'd0;
         busy_q       <= 1'b0;
         settled_q    <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         err_q   <= zero_req;
         phase_q <= wrap ? 4'd0 : phase_q + 4'd1;
         if (start) begin
            pend_n_q  <= bus.req_n;
            busy_q    <= 1'b1;
            settled_q <= 1'b0;
         end
         if (apply) begin
            n_q          <= pend_n_q;
            settle_cnt_q <= 4'd0;
         end else if (state_q == SETTLE) begin
            settle_cnt_q <= settle_cnt_q + 4'd1;
         end
`ifdef DIV_DITHER_EN
         // Per-period ratio: one longer period after each accumulator carry.
         if (!apply && wrap) n_q <= dsum[3] ? n_up : base_q;
`endif
         if (settle_done) begin
            busy_q    <= 1'b0;
            settled_q <= 1'b1;
         end
      end
   end

`ifdef DIV_DITHER_EN
   always_ff @(posedge CLK_out or negedge rst_n) begin
      if (!rst_n) begin
         base_q      <= RESET_N;
         frac_q      <= 3'd0;
         pend_frac_q <= 3'd0;
         acc_q       <= 3'd0;
      end else begin
         if (start) begin
            pend_frac_q <= bus.req_frac;
            acc_q       <= 3'd0;
         end else if (apply) begin
            base_q <= pend_n_q;
            frac_q <= pend_frac_q;
            acc_q  <= 3'd0;
         end else if (wrap) begin
            acc_q <= dsum[2:0];
         end
      end
   end
`endif

   assign bus.req_ready = ready;
   assign bus.n_out     = n_q;
   assign bus.wrap      = wrap;
   assign bus.busy      = busy_q;
   assign bus.settled   = settled_q;
   assign bus.err       = err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_div_ratio_sched.sv
// tb_div_ratio_sched
//   Directed bench for div_ratio_sched: reset, ratio switch from 1, switch
//   mid-period from 7, zero-ratio rejection, repeat request, reset during
//   SETTLE and (dither build) the fractional period mix.
module tb_div_ratio_sched;

   logic       CLK_out;
   logic       rst_n;
   logic [1:0] state_dbg;
   int         vectors;
   int         miscompares;
   int         cnt;

   div_ratio_sched_if bus ();

   div_ratio_sched dut (
      .CLK_out   (CLK_out),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial CLK_out = 1'b0;
   always #5 CLK_out = ~CLK_out;

   task automatic step();
      @(posedge CLK_out);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [2:0] n, input logic [2:0] frac);
      bus.req_valid = 1'b1;
      bus.req_n     = n;
      bus.req_frac  = frac;
      step();
      bus.req_valid = 1'b0;
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_n     = 3'd0;
      bus.req_frac  = 3'd0;

      // Reset values
      #12;
      chk("rst_n_out", 8'(bus.n_out), 8'd1);
      chk("rst_busy", 8'(bus.busy), 8'd0);
      chk("rst_settled", 8'(bus.settled), 8'd1);
      chk("rst_err", 8'(bus.err), 8'd0);
      chk("rst_state", 8'(state_dbg), 8'd0);
      @(negedge CLK_out);
      rst_n = 1'b1;

      // Idle after reset: ratio 1, wrap every cycle
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_ready", 8'(bus.req_ready), 8'd1);
         chk("idle_wrap", 8'(bus.wrap), 8'd1);
         chk("idle_n_out", 8'(bus.n_out), 8'd1);
         chk("idle_settled", 8'(bus.settled), 8'd1);
      end

      // 1 -> 5: applied on the edge after the handshake
      request(3'd5, 3'd0);
      chk("sw5_state", 8'(state_dbg), 8'd1);
      chk("sw5_busy", 8'(bus.busy), 8'd1);
      chk("sw5_settled", 8'(bus.settled), 8'd0);
      chk("sw5_ready", 8'(bus.req_ready), 8'd0);
      chk("sw5_n_old", 8'(bus.n_out), 8'd1);
      step();
      chk("sw5_n_new", 8'(bus.n_out), 8'd5);
      chk("sw5_settle_state", 8'(state_dbg), 8'd2);
      chk("sw5_wrap0", 8'(bus.wrap), 8'd0);
      for (int k = 1; k <= 14; k++) begin
         step();
         chk("sw5_wrap", 8'(bus.wrap), ((k % 5) == 4) ? 8'd1 : 8'd0);
         chk("sw5_busy_run", 8'(bus.busy), (k <= 7) ? 8'd1 : 8'd0);
         chk("sw5_settled_run", 8'(bus.settled), (k <= 7) ? 8'd0 : 8'd1);
      end

      // 5 -> 7, then 7 -> 3 requested while phase == 1
      request(3'd7, 3'd0);
      cnt = 0;
      while (bus.n_out !== 3'd7 && cnt < 20) begin step(); cnt++; end
      chk("sw7_n_out", 8'(bus.n_out), 8'd7);
      cnt = 0;
      while (bus.busy !== 1'b0 && cnt < 20) begin step(); cnt++; end
      chk("sw7_busy_done", 8'(bus.busy), 8'd0);
      cnt = 0;
      while (bus.wrap !== 1'b1 && cnt < 10) begin step(); cnt++; end
      chk("sw7_wrap_found", 8'(bus.wrap), 8'd1);
      step();
      step();
      request(3'd3, 3'd0);
      for (int p = 2; p <= 6; p++) begin
         chk("sw3_n_hold", 8'(bus.n_out), 8'd7);
         chk("sw3_ready", 8'(bus.req_ready), 8'd0);
         chk("sw3_wrap", 8'(bus.wrap), (p == 6) ? 8'd1 : 8'd0);
         if (p < 6) step();
      end
      step();
      chk("sw3_n_new", 8'(bus.n_out), 8'd3);
      chk("sw3_state", 8'(state_dbg), 8'd2);
      cnt = 0;
      while (bus.busy !== 1'b0 && cnt < 20) begin step(); cnt++; end
      chk("sw3_settled", 8'(bus.settled), 8'd1);

      // Zero ratio rejected with a one-cycle err pulse
      request(3'd0, 3'd0);
      chk("zero_err", 8'(bus.err), 8'd1);
      chk("zero_state", 8'(state_dbg), 8'd0);
      chk("zero_n_out", 8'(bus.n_out), 8'd3);
      chk("zero_busy", 8'(bus.busy), 8'd0);
      chk("zero_settled", 8'(bus.settled), 8'd1);
      step();
      chk("zero_err_drop", 8'(bus.err), 8'd0);

      // Repeat of the current ratio: nothing changes
      request(3'd3, 3'd0);
      chk("same_state", 8'(state_dbg), 8'd0);
      chk("same_busy", 8'(bus.busy), 8'd0);
      chk("same_settled", 8'(bus.settled), 8'd1);
      chk("same_err", 8'(bus.err), 8'd0);

      // Reset during SETTLE after switching to 4
      request(3'd4, 3'd0);
      cnt = 0;
      while (state_dbg !== 2'd2 && cnt < 10) begin step(); cnt++; end
      chk("sw4_n_out", 8'(bus.n_out), 8'd4);
      chk("sw4_busy", 8'(bus.busy), 8'd1);
      step();
      step();
      rst_n = 1'b0;
      #2;
      chk("abort_n_out", 8'(bus.n_out), 8'd1);
      chk("abort_busy", 8'(bus.busy), 8'd0);
      chk("abort_settled", 8'(bus.settled), 8'd1);
      chk("abort_state", 8'(state_dbg), 8'd0);
      @(negedge CLK_out);
      rst_n = 1'b1;
      step();
      chk("post_ready", 8'(bus.req_ready), 8'd1);
      chk("post_n_out", 8'(bus.n_out), 8'd1);
      chk("post_wrap", 8'(bus.wrap), 8'd1);

`ifdef DIV_DITHER_EN
      // 4 + 2/8: every fourth period is 5 cycles long
      begin
         int len;
         int fives;
         int total;
         fives = 0;
         total = 0;
         request(3'd4, 3'd2);
         cnt = 0;
         while (state_dbg !== 2'd2 && cnt < 10) begin step(); cnt++; end
         chk("dith_apply", 8'(bus.n_out), 8'd4);
         cnt = 0;
         while (bus.wrap !== 1'b1 && cnt < 10) begin step(); cnt++; end
         chk("dith_wrap_found", 8'(bus.wrap), 8'd1);
         for (int p = 0; p < 16; p++) begin
            len = 0;
            do begin
               step();
               len++;
            end while (bus.wrap !== 1'b1 && len < 10);
            total += len;
            if (len == 5) fives++;
         end
         chk("dith_fives", 8'(fives), 8'd4);
         chk("dith_total", 8'(total), 8'd68);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
